// File: rtl/gemm_vec_feeder_if.sv
// Handshake bundle between the vector feeder, its upstream source and the GEMM core.
// The feeder takes the slave modport; the source/GEMM side takes master.
interface gemm_vec_feeder_if #(
  parameter int NBits       = 12,
  parameter int WorkingRegs = 4
);
  logic                         s_valid;
  logic [NBits-1:0]             s_data;
  logic                         s_ready;
  logic                         in_data_ready;
  logic [WorkingRegs*NBits-1:0] in_data;
  logic                         req_chunk_in;
  logic                         req_chunk_ptr_rst;
  logic                         req_chunk_out;
  logic [NBits-1:0]             write_out_data;
  logic                         m_valid;
  logic [NBits-1:0]             m_data;
  logic                         m_last;
  logic                         busy;
  logic                         proto_err;

  modport slave (
    input  s_valid, s_data, req_chunk_in, req_chunk_ptr_rst, req_chunk_out, write_out_data,
    output s_ready, in_data_ready, in_data, m_valid, m_data, m_last, busy, proto_err
  );

  modport master (
    output s_valid, s_data, req_chunk_in, req_chunk_ptr_rst, req_chunk_out, write_out_data,
    input  s_ready, in_data_ready, in_data, m_valid, m_data, m_last, busy, proto_err
  );
endinterface

// File: rtl/gemm_vec_feeder.sv
// Input-vector buffer and chunk sequencer for one GEMM layer: fill, strobe start,
// serve chunks, forward OutVecLength results, then release the buffer.
module gemm_vec_feeder #(
  parameter int InVecLength  = 16,
  parameter int OutVecLength = 8,
  parameter int WorkingRegs  = 4,
  parameter int NBits        = 12
) (
  input  logic          clk_in,
  input  logic          rst_in,
  gemm_vec_feeder_if.slave bus
);
  localparam int Chunks = InVecLength / WorkingRegs;
  localparam int CW     = $clog2(Chunks);
  localparam int RW     = CW + 1;
  localparam int LW     = $clog2(WorkingRegs);
  localparam int OW     = $clog2(OutVecLength);

  typedef enum logic [1:0] {FILL, START, SERVE} state_e;

  state_e           state_q, state_d;
  logic [NBits-1:0] buf_q [Chunks][WorkingRegs];
  logic [CW-1:0]    wr_chunk_q;
  logic [LW-1:0]    wr_lane_q;
  logic [RW-1:0]    rd_ptr_q;
  logic [OW-1:0]    out_cnt_q;
  logic             m_valid_q, m_last_q, proto_err_q;
  logic [NBits-1:0] m_data_q;
  logic [WorkingRegs*NBits-1:0] in_data_w;

  logic last_wr, last_out, any_req;

  assign last_wr  = (wr_chunk_q == CW'(Chunks - 1)) && (wr_lane_q == LW'(WorkingRegs - 1));
  assign last_out = bus.req_chunk_out && (out_cnt_q == OW'(OutVecLength - 1));
  assign any_req  = bus.req_chunk_in | bus.req_chunk_ptr_rst | bus.req_chunk_out;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (bus.s_valid && last_wr) state_d = START;
      START:   state_d = SERVE;
      SERVE:   if (last_out) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int c = 0; c < Chunks; c++)
        for (int k = 0; k < WorkingRegs; k++)
          buf_q[c][k] <= '0;
      wr_chunk_q  <= '0;
      wr_lane_q   <= '0;
      rd_ptr_q    <= '0;
      out_cnt_q   <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      // GEMM requests are only legal while serving; elsewhere they only flag
      if (state_q != SERVE && any_req) proto_err_q <= 1'b1;
      case (state_q)
        FILL: begin
          if (bus.s_valid) begin
            buf_q[wr_chunk_q][wr_lane_q] <= bus.s_data;
            if (wr_lane_q == LW'(WorkingRegs - 1)) begin
              wr_lane_q  <= '0;
              wr_chunk_q <= last_wr ? '0 : wr_chunk_q + 1'b1;
            end else begin
              wr_lane_q <= wr_lane_q + 1'b1;
            end
            if (last_wr) rd_ptr_q <= '0;
          end
        end
        SERVE: begin
          if (bus.req_chunk_ptr_rst)
            rd_ptr_q <= '0;
          else if (bus.req_chunk_in)
            rd_ptr_q <= (rd_ptr_q == RW'(Chunks - 1)) ? '0 : rd_ptr_q + 1'b1;
          if (bus.req_chunk_out) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.write_out_data;
            m_last_q  <= last_out;
            out_cnt_q <= last_out ? '0 : out_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_data_w = '0;
    for (int k = 0; k < WorkingRegs; k++)
      in_data_w[k*NBits +: NBits] = buf_q[rd_ptr_q[CW-1:0]][k];
  end

  assign bus.in_data       = in_data_w;
  assign bus.s_ready       = (state_q == FILL);
  assign bus.in_data_ready = (state_q == START);
  assign bus.busy          = (state_q != FILL);
  assign bus.m_valid       = m_valid_q;
  assign bus.m_data        = m_data_q;
  assign bus.m_last        = m_last_q;
  assign bus.proto_err     = proto_err_q;
endmodule

// File: tb/tb_gemm_vec_feeder.sv
// Randomized bench for gemm_vec_feeder against a vector-level reference model.
module tb_gemm_vec_feeder;
  localparam int InVecLength  = 16;
  localparam int OutVecLength = 8;
  localparam int WorkingRegs  = 4;
  localparam int NBits        = 12;
  localparam int Chunks       = InVecLength / WorkingRegs;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  gemm_vec_feeder_if #(.NBits(NBits), .WorkingRegs(WorkingRegs)) bus();

  gemm_vec_feeder #(
    .InVecLength(InVecLength), .OutVecLength(OutVecLength),
    .WorkingRegs(WorkingRegs), .NBits(NBits)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: phase 0 collecting, 1 start strobe, 2 serving
  int         mdl_phase, mdl_n, mdl_ptr, mdl_cnt;
  logic [11:0] mdl_buf [InVecLength];
  logic        mdl_mv, mdl_ml, mdl_perr;
  logic [11:0] mdl_md;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rn, input logic sv, input logic [11:0] sd,
                            input logic rin, input logic rrst, input logic rout,
                            input logic [11:0] wod);
    if (!rn) begin
      mdl_phase = 0; mdl_n = 0; mdl_ptr = 0; mdl_cnt = 0;
      for (int i = 0; i < InVecLength; i++) mdl_buf[i] = '0;
      mdl_mv = 0; mdl_ml = 0; mdl_md = '0; mdl_perr = 0;
    end else begin
      mdl_mv = 0; mdl_ml = 0;
      if (mdl_phase == 2) begin
        if (rrst)     mdl_ptr = 0;
        else if (rin) mdl_ptr = (mdl_ptr + 1) % Chunks;
        if (rout) begin
          mdl_mv = 1; mdl_md = wod; mdl_ml = (mdl_cnt == OutVecLength - 1);
          mdl_cnt++;
          if (mdl_cnt == OutVecLength) begin mdl_cnt = 0; mdl_phase = 0; end
        end
      end else begin
        if (rin || rrst || rout) mdl_perr = 1;
        if (mdl_phase == 1) mdl_phase = 2;
        else if (sv) begin
          mdl_buf[mdl_n] = sd;
          mdl_n++;
          if (mdl_n == InVecLength) begin mdl_n = 0; mdl_ptr = 0; mdl_phase = 1; end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [47:0] e;
    e = '0;
    for (int k = 0; k < WorkingRegs; k++) e[k*12 +: 12] = mdl_buf[mdl_ptr*WorkingRegs + k];
    chk("s_ready",       bus.s_ready,       64'(mdl_phase == 0));
    chk("in_data_ready", bus.in_data_ready, 64'(mdl_phase == 1));
    chk("busy",          bus.busy,          64'(mdl_phase != 0));
    chk("in_data",       bus.in_data,       64'(e));
    chk("m_valid",       bus.m_valid,       64'(mdl_mv));
    chk("m_last",        bus.m_last,        64'(mdl_ml));
    chk("m_data",        bus.m_data,        64'(mdl_md));
    chk("proto_err",     bus.proto_err,     64'(mdl_perr));
  endtask

  task automatic tick(input logic rn, input logic sv, input logic [11:0] sd,
                      input logic rin, input logic rrst, input logic rout,
                      input logic [11:0] wod);
    rst_in = rn; bus.s_valid = sv; bus.s_data = sd;
    bus.req_chunk_in = rin; bus.req_chunk_ptr_rst = rrst;
    bus.req_chunk_out = rout; bus.write_out_data = wod;
    @(posedge clk_in);
    model_step(rn, sv, sd, rin, rrst, rout, wod);
    #1;
    check_all();
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 12'h0);
  endtask

  // gap: 0 continuous, 1 toggle, 2 random; seq uses element index as data
  task automatic fill_vector(input int gap, input bit seq);
    int cyc;
    logic sv;
    cyc = 0;
    while (mdl_phase == 0 && cyc < 200) begin
      sv = (gap == 0) ? 1'b1 : (gap == 1) ? logic'(cyc % 2 == 0) : logic'($urandom_range(0, 1));
      tick(1'b1, sv, seq ? 12'(mdl_n) : 12'($urandom), 1'b0, 1'b0, 1'b0, 12'h0);
      cyc++;
    end
    chk("fill_done", bus.in_data_ready, 64'd1);
  endtask

  task automatic serve_random(output int outs);
    int cyc;
    cyc = 0; outs = 0;
    while (mdl_phase != 0 && cyc < 300) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)),
           logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 2) == 0), 12'($urandom));
      if (bus.m_valid) outs++;
      cyc++;
    end
    chk("drain_busy", bus.busy, 64'd0);
  endtask

  initial begin
    int outs;
    bus.s_valid = 0; bus.s_data = '0; bus.req_chunk_in = 0; bus.req_chunk_ptr_rst = 0;
    bus.req_chunk_out = 0; bus.write_out_data = '0; rst_in = 0;

    // reset and sequential fill
    tick(1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 12'h0);
    tick(1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 12'h0);
    chk("rst_s_ready", bus.s_ready, 64'd1);
    chk("rst_m_valid", bus.m_valid, 64'd0);
    chk("rst_m_data",  bus.m_data,  64'd0);
    chk("rst_busy",    bus.busy,    64'd0);
    chk("rst_perr",    bus.proto_err, 64'd0);
    fill_vector(0, 1'b1);
    chk("t1_sready_low", bus.s_ready, 64'd0);
    chk("t1_chunk0", bus.in_data, 64'h003_002_001_000);
    idle();
    chk("t1_strobe_1cyc", bus.in_data_ready, 64'd0);

    // chunk pointer stepping, wrap, and rewind priority
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 12'h0);
    chk("t2_chunk3", bus.in_data, 64'h00f_00e_00d_00c);
    tick(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 12'h0);
    chk("t2_wrap", bus.in_data, 64'h003_002_001_000);
    tick(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 12'h0);
    tick(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 12'h0);
    tick(1'b1, 1'b0, 12'h0, 1'b1, 1'b1, 1'b0, 12'h0);
    chk("t2_rst_prio", bus.in_data, 64'h003_002_001_000);

    // eight results forwarded
    for (int i = 0; i < OutVecLength; i++) begin
      tick(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 12'(32'h100 + i));
      chk("t3_m_data", bus.m_data, 64'(32'h100 + i));
      chk("t3_m_last", bus.m_last, 64'(i == OutVecLength - 1));
    end
    chk("t3_s_ready", bus.s_ready, 64'd1);
    idle();
    chk("t3_m_valid_clr", bus.m_valid, 64'd0);

    // gapped fills and random serving across several vectors
    fill_vector(1, 1'b0);
    idle();
    serve_random(outs);
    chk("t4_outs", 64'(outs), 64'(OutVecLength));
    for (int v = 0; v < 8; v++) begin
      fill_vector(2, 1'b0);
      idle();
      serve_random(outs);
      chk("rand_outs", 64'(outs), 64'(OutVecLength));
    end

    // reset in the middle of serving
    fill_vector(0, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 12'($urandom));
    tick(1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 12'h5a5);
    chk("t5_state_fill", bus.s_ready, 64'd1);
    for (int i = 0; i < 3; i++) idle();
    fill_vector(2, 1'b0);
    idle();
    serve_random(outs);
    chk("t5_outs", 64'(outs), 64'(OutVecLength));

    // protocol error in FILL: sticky, otherwise ignored
    tick(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 12'h777);
    chk("t6_perr", bus.proto_err, 64'd1);
    chk("t6_no_mvalid", bus.m_valid, 64'd0);
    fill_vector(0, 1'b0);
    tick(1'b1, 1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 12'h0);
    serve_random(outs);
    chk("t6_outs", 64'(outs), 64'(OutVecLength));
    chk("t6_sticky", bus.proto_err, 64'd1);
    tick(1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 12'h0);
    chk("t6_perr_clr", bus.proto_err, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
